// File: rtl/proc_arb_if.sv
// Requester / processor / response bundle shared by proc_arb and its environment.
interface proc_arb_if;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_last;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_last;
  logic        req1_ready;
  logic [15:0] proc_din;
  logic [15:0] proc_dout;
  logic        resp_valid;
  logic        resp_id;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [1:0]  grant;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  proc_dout,
    output req0_ready, req1_ready, proc_din,
    output resp_valid, resp_id, resp_data, resp_err, grant
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output proc_dout,
    input  req0_ready, req1_ready, proc_din,
    input  resp_valid, resp_id, resp_data, resp_err, grant
  );
endinterface

// File: rtl/proc_arb.sv
// Two-requester round-robin packet arbiter feeding a slow processor one held word at a time.
// Define PROC_ARB_TIMEOUT_EN to abort packets that stall for 255 cycles (resp_err = 1).
module proc_arb #(
  parameter int          HOLD_CYCLES = 4,
  parameter int          RESP_DELAY  = 8,
  parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  proc_arb_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_STALL, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] DELAY_LAST = 8'(RESP_DELAY - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic        last_q, last_d;
  logic        resp_id_q, resp_id_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic [15:0] word_q, word_d;
`ifdef PROC_ARB_TIMEOUT_EN
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        resp_err_q, resp_err_d;
`endif

  logic        sel;
  logic        own_valid;
  logic [15:0] own_data;
  logic        own_last;
  logic        rdy_en;
  logic        rdy_who;

  always_comb begin
    // Both valid: the favoured requester wins; otherwise whoever is valid.
    sel       = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    own_valid = owner_q ? bus.req1_valid : bus.req0_valid;
    own_data  = owner_q ? bus.req1_data  : bus.req0_data;
    own_last  = owner_q ? bus.req1_last  : bus.req0_last;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    last_d      = last_q;
    word_d      = word_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
`ifdef PROC_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    resp_err_d  = resp_err_q;
`endif
    rdy_en      = 1'b0;
    rdy_who     = owner_q;
    case (state_q)
      S_IDLE: begin
        rdy_who = sel;
        rdy_en  = bus.req0_valid || bus.req1_valid;
        if (rdy_en) begin
          owner_d = sel;
          prio_d  = ~sel;
          word_d  = sel ? bus.req1_data : bus.req0_data;
          last_d  = sel ? bus.req1_last : bus.req0_last;
          cnt_d   = 8'd0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 8'd0;
          if (last_q) begin
            state_d = S_WAIT;
          end else begin
            // Offer the next word in the final hold cycle so it follows without a gap.
            rdy_en = 1'b1;
            if (own_valid) begin
              word_d = own_data;
              last_d = own_last;
            end else begin
              state_d = S_STALL;
`ifdef PROC_ARB_TIMEOUT_EN
              to_cnt_d = 8'd0;
`endif
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_STALL: begin
        rdy_en = 1'b1;
        if (own_valid) begin
          word_d  = own_data;
          last_d  = own_last;
          cnt_d   = 8'd0;
          state_d = S_HOLD;
        end else begin
`ifdef PROC_ARB_TIMEOUT_EN
          if (to_cnt_q == 8'd254) begin
            state_d     = S_RESP;
            resp_id_d   = owner_q;
            resp_data_d = 16'h0000;
            resp_err_d  = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == DELAY_LAST) begin
          cnt_d       = 8'd0;
          state_d     = S_RESP;
          resp_id_d   = owner_q;
          resp_data_d = bus.proc_dout;
`ifdef PROC_ARB_TIMEOUT_EN
          resp_err_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      last_q      <= 1'b0;
      resp_id_q   <= 1'b0;
      resp_data_q <= 16'h0000;
`ifdef PROC_ARB_TIMEOUT_EN
      to_cnt_q    <= 8'd0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      last_q      <= last_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
`ifdef PROC_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      resp_err_q  <= resp_err_d;
`endif
    end
  end

  // The held word is only visible in HOLD, so it needs no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  // Ready is masked by rst so it drops the instant reset asserts.
  assign bus.req0_ready = rdy_en && !rdy_who && !rst;
  assign bus.req1_ready = rdy_en &&  rdy_who && !rst;
  assign bus.proc_din   = (state_q == S_HOLD) ? word_q : IDLE_WORD;
  assign bus.grant      = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
`ifdef PROC_ARB_TIMEOUT_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_proc_arb.sv
// Bench for proc_arb: directed and random packets checked against a cycle-count model of the protocol.
module tb_proc_arb;
  localparam int          H         = 4;
  localparam int          D         = 8;
  localparam logic [15:0] IDLE_WORD = 16'h0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   rr_last;

  proc_arb_if bus ();

  proc_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input bit v, input logic [15:0] d, input bit l);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Round-robin model: with both valid, the requester not served last wins.
  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return (rr_last == 0) ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  // One packet from acceptance in IDLE to the end of its RESP cycle.
  // gap[k] > 0: owner valid is low for gap[k]-1 cycles before word k, giving gap[k] idle cycles.
  task automatic run_packet(input int own, input bit other_v, input logic [15:0] w[$], input int gap[$]);
    int          nw;
    int          oth;
    logic [1:0]  g;
    logic [15:0] pd;
    bit          more;
    bit          cont;
    nw  = w.size();
    oth = 1 - own;
    g   = (own == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(own, 1'b1, w[0], nw == 1);
    drive(oth, other_v, 16'($urandom), 1'b1);
    #1;
    chk("idle_ready_own", 16'(rdy(own)), 16'd1);
    chk("idle_ready_other", 16'(rdy(oth)), 16'd0);
    chk("idle_grant", 16'(bus.grant), 16'd0);
    chk("idle_din", bus.proc_din, IDLE_WORD);
    for (int k = 0; k < nw; k++) begin
      more = (k < nw - 1);
      cont = more && (gap[k+1] == 0);
      for (int c = 0; c < H; c++) begin
        @(negedge clk);
        if (cont) drive(own, 1'b1, w[k+1], (k + 1) == (nw - 1));
        else      drive(own, 1'b0, 16'h0000, 1'b0);
        #1;
        chk("hold_din", bus.proc_din, w[k]);
        chk("hold_grant", 16'(bus.grant), 16'(g));
        chk("hold_ready_own", 16'(rdy(own)), 16'((c == H - 1) && more));
        chk("hold_ready_other", 16'(rdy(oth)), 16'd0);
        chk("hold_resp", 16'(bus.resp_valid), 16'd0);
      end
      if (more && gap[k+1] > 0) begin
        for (int s = 0; s < gap[k+1]; s++) begin
          @(negedge clk);
          if (s == gap[k+1] - 1) drive(own, 1'b1, w[k+1], (k + 1) == (nw - 1));
          else                   drive(own, 1'b0, 16'h0000, 1'b0);
          #1;
          chk("stall_din", bus.proc_din, IDLE_WORD);
          chk("stall_ready_own", 16'(rdy(own)), 16'd1);
          chk("stall_ready_other", 16'(rdy(oth)), 16'd0);
          chk("stall_grant", 16'(bus.grant), 16'(g));
        end
      end
    end
    pd = 16'h0000;
    for (int c = 0; c < D; c++) begin
      @(negedge clk);
      drive(own, 1'b0, 16'h0000, 1'b0);
      pd = 16'($urandom);
      bus.proc_dout = pd;
      #1;
      chk("wait_din", bus.proc_din, IDLE_WORD);
      chk("wait_grant", 16'(bus.grant), 16'(g));
      chk("wait_resp", 16'(bus.resp_valid), 16'd0);
      chk("wait_ready_other", 16'(rdy(oth)), 16'd0);
    end
    @(negedge clk);
    bus.proc_dout = ~pd;
    #1;
    chk("resp_valid", 16'(bus.resp_valid), 16'd1);
    chk("resp_id", 16'(bus.resp_id), 16'(own));
    chk("resp_data", bus.resp_data, pd);
    chk("resp_err", 16'(bus.resp_err), 16'd0);
    chk("resp_grant", 16'(bus.grant), 16'(g));
    chk("resp_ready_other", 16'(rdy(oth)), 16'd0);
  endtask

  initial begin
    logic [15:0] wq[$];
    int          gq[$];
    int          own;
    int          n;
    bit          v0;
    bit          v1;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.proc_dout = 16'h0000;
    drive(0, 1'b1, 16'h1111, 1'b1);
    drive(1, 1'b1, 16'h2222, 1'b1);
    #1;
    chk("rst_ready0", 16'(bus.req0_ready), 16'd0);
    chk("rst_ready1", 16'(bus.req1_ready), 16'd0);
    chk("rst_grant", 16'(bus.grant), 16'd0);
    chk("rst_din", bus.proc_din, IDLE_WORD);
    chk("rst_resp_valid", 16'(bus.resp_valid), 16'd0);
    chk("rst_resp_id", 16'(bus.resp_id), 16'd0);
    chk("rst_resp_data", bus.resp_data, 16'h0000);
    chk("rst_resp_err", 16'(bus.resp_err), 16'd0);
    drive(0, 1'b0, 16'h0000, 1'b0);
    drive(1, 1'b0, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_last = 1;

    // Single-word packet, then a contiguous three-word packet.
    wq = '{16'h0040}; gq = '{0};
    own = pick(1'b1, 1'b0); rr_last = own;
    run_packet(own, 1'b0, wq, gq);
    wq = '{16'h0008, 16'h0155, 16'h0081}; gq = '{0, 0, 0};
    own = pick(1'b1, 1'b0); rr_last = own;
    run_packet(own, 1'b0, wq, gq);

    // Both valid from reset: grants alternate 0, 1, 0.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    rr_last = 1;
    for (int p = 0; p < 3; p++) begin
      wq = '{16'($urandom), 16'($urandom)}; gq = '{0, 0};
      own = pick(1'b1, 1'b1); rr_last = own;
      run_packet(own, 1'b1, wq, gq);
    end

    // req1 owns the bus and drops valid for 10 cycles mid-packet; req0 stays blocked.
    wq = '{16'h0A01, 16'h0A02, 16'h0A03}; gq = '{0, 0, 10};
    own = pick(1'b1, 1'b1); rr_last = own;
    run_packet(own, 1'b1, wq, gq);

    for (int p = 0; p < 8; p++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      own = pick(v0, v1); rr_last = own;
      n = $urandom_range(1, 4);
      wq.delete(); gq.delete();
      for (int k = 0; k < n; k++) begin
        wq.push_back(16'($urandom));
        gq.push_back((k == 0) ? 0 : $urandom_range(0, 3));
      end
      run_packet(own, (own == 0) ? v1 : v0, wq, gq);
    end

    // Reset asserted between edges during HOLD.
    @(negedge clk);
    drive(0, 1'b1, 16'h1234, 1'b0);
    drive(1, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_hold_din", bus.proc_din, 16'h1234);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", 16'(bus.grant), 16'd0);
    chk("async_rst_din", bus.proc_din, IDLE_WORD);
    chk("async_rst_ready0", 16'(bus.req0_ready), 16'd0);
    chk("async_rst_resp", 16'(bus.resp_valid), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 16'h0000, 1'b0);
    rr_last = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("post_rst_no_resp", 16'(bus.resp_valid), 16'd0);
      chk("post_rst_grant", 16'(bus.grant), 16'd0);
    end

    // Long stall mid-packet: aborts after 255 stall cycles only in the timeout build.
    @(negedge clk);
    drive(0, 1'b1, 16'h00A5, 1'b0);
    #1;
    chk("stall_pkt_ready", 16'(bus.req0_ready), 16'd1);
    for (int c = 0; c < H; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 16'h0000, 1'b0);
      bus.proc_dout = 16'hBEEF;
      #1;
      chk("stall_pkt_din", bus.proc_din, 16'h00A5);
      chk("stall_pkt_ready_fin", 16'(bus.req0_ready), 16'(c == H - 1));
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
`ifdef PROC_ARB_TIMEOUT_EN
      if (i == 255) begin
        chk("timeout_resp_valid", 16'(bus.resp_valid), 16'd1);
        chk("timeout_resp_err", 16'(bus.resp_err), 16'd1);
        chk("timeout_resp_data", bus.resp_data, 16'h0000);
        chk("timeout_resp_id", 16'(bus.resp_id), 16'd0);
        break;
      end
`endif
      chk("long_stall_no_resp", 16'(bus.resp_valid), 16'd0);
      chk("long_stall_din", bus.proc_din, IDLE_WORD);
    end
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    #1;
    chk("final_grant", 16'(bus.grant), 16'd0);
    chk("final_resp", 16'(bus.resp_valid), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/proc_arb.md
PROC_ARB -- requirements
Module: proc_arb

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of clk cycles each accepted word is presented to the processor data input.
REQ-002 Parameter RESP_DELAY, default 8, cycles waited after a packet's last word before sampling the processor result.
REQ-003 Parameter IDLE_WORD, default 16'h0000, value driven to the processor when no word is being presented.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0_valid / req1_valid  input  1  requester n has a word on reqn_data.
REQ-007 req0_data / req1_data  input  16  instruction or operand word.
REQ-008 req0_last / req1_last  input  1  word is the final word of its packet.
REQ-009 req0_ready / req1_ready  output  1  word accepted on a rising edge where reqn_valid && reqn_ready.
REQ-010 proc_din  output  16  drives the processor data_in.
REQ-011 proc_dout  input  16  processor data_out.
REQ-012 resp_valid  output  1  one-cycle pulse: response available.
REQ-013 resp_id  output  1  requester owning the response.
REQ-014 resp_data  output  16  sampled proc_dout.
REQ-015 resp_err  output  1  packet aborted (timeout build only, else 0).
REQ-016 grant  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-017 States SHALL be IDLE, HOLD, STALL, WAIT, RESP.
REQ-018 IDLE: proc_din = IDLE_WORD, grant = 00; the selected requester's ready SHALL be 1 combinationally when its valid is 1.
REQ-019 Selection: one valid requester wins; both valid -> requester not granted last (round-robin pointer), pointer updated on each packet's first-word acceptance.
REQ-020 On acceptance, the word SHALL be registered and appear on proc_din from the next cycle for exactly HOLD_CYCLES cycles (state HOLD); grant held one-hot for the whole packet.
REQ-021 The owner SHALL NOT change mid-packet; the other requester's ready stays 0 until the packet's response completes.
REQ-022 In the final HOLD cycle of a non-last word, owner's ready = 1; if accepted, the next word follows with no gap; if owner valid = 0, go to STALL.
REQ-023 STALL: proc_din = IDLE_WORD, owner ready = 1; acceptance -> HOLD with the new word next cycle.
REQ-024 After the HOLD of a last word: WAIT for RESP_DELAY cycles with proc_din = IDLE_WORD, then RESP.
REQ-025 RESP (one cycle): resp_data <= proc_dout sampled at WAIT's final edge, resp_valid = 1, resp_id = owner, then IDLE; a new packet may be accepted the cycle after RESP.
REQ-026 Single-word packet (last = 1 on first word) SHALL go HOLD -> WAIT directly.
REQ-027 Hold and delay counters SHALL be 8-bit, compare against parameter-1; HOLD_CYCLES and RESP_DELAY of 0 are illegal.

Reset
REQ-028 On rst = 1, immediately: state IDLE, proc_din = IDLE_WORD, all ready, resp_valid, resp_err, grant, resp_id = 0, resp_data = 16'h0000, counters 0, round-robin pointer favours req0.
REQ-029 Reset mid-packet SHALL discard the packet without emitting a response.

Configuration
REQ-030 With PROC_ARB_TIMEOUT_EN defined: an 8-bit counter in STALL; after 255 cycles without acceptance, abort packet, go to RESP with resp_err = 1, resp_data = 16'h0000.
REQ-031 Without PROC_ARB_TIMEOUT_EN: STALL lasts indefinitely; resp_err tied 0.

Verification
REQ-032 Reset, req0 sends single word 16'h0040 (last = 1) -> proc_din = 16'h0040 for 4 cycles, then 8 cycles 16'h0000, resp_valid pulse, resp_id = 0, resp_data = proc_dout value.
REQ-033 req0 sends 3-word packet 16'h0008, 16'h0155, 16'h0081 with valid held -> 12 contiguous cycles of words, no gap, one response.
REQ-034 Both valid from reset -> req0 granted first, req1 ready = 0 until req0 response, req1 granted next; repeat both valid -> alternates 0, 1, 0.
REQ-035 req1 drops valid for 10 cycles between words -> proc_din = 16'h0000 for those cycles, packet resumes, req0 stays blocked.
REQ-036 Timeout build: req0 stalls 300 cycles mid-packet -> after 255 cycles resp_valid with resp_err = 1; non-timeout build -> no response.
REQ-037 rst asserted during HOLD -> outputs reach reset values without waiting for a clock edge, no resp_valid pulse.
